// File: rtl/ctrl_decoder.sv
// ctrl_decoder: main instruction decoder for the 9-bit accumulator processor.
//
// Splits Instruction into opcode [8:4] and operand [3:0], and decodes the
// opcode combinationally into datapath enables and mux selects. The only
// state is the sticky program-done flag Ack, set by HALT and cleared by reset.
//
// Ports:
//   Clk, Reset_n           clock (rising edge), synchronous active-low reset
//   Instruction[8:0]       current instruction
//   AccInput[7:0]          accumulator value, used by BEQZ / BNEZ
//   PC_Jmp_Flag/PC_Beq_Flag  PC loads the branch LUT target
//   LUT_*                  branch LUT write/read controls
//   Reg_*                  register file write enable and data select
//   Acc_*                  accumulator write enable, data select, nibble select
//   Mem_Write_En           data memory write
//   Ack                    program done (sticky)
//   ALU_Opcode[4:0]        ALU function select
//   op_mnemonic[4:0]       debug copy of the opcode field
module ctrl_decoder (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [8:0] Instruction,
  input  logic [7:0] AccInput,
  output logic       PC_Jmp_Flag,
  output logic       PC_Beq_Flag,
  output logic       LUT_Write_En,
  output logic       LUT_Read_En,
  output logic       LUT_Load_Hi,
  output logic       Reg_Write_En,
  output logic       Reg_From_ALU,
  output logic       Reg_From_Mem,
  output logic       Reg_From_Acc,
  output logic       Acc_Write_En,
  output logic       Acc_From_Reg,
  output logic       Acc_From_ALU,
  output logic       Acc_From_Imm,
  output logic       Acc_Load_Hi,
  output logic       Mem_Write_En,
  output logic       Ack,
  output logic [4:0] ALU_Opcode,
  output logic [4:0] op_mnemonic
);

  logic [4:0] opcode;
  assign opcode      = Instruction[8:4];
  assign op_mnemonic = opcode;

  // The operand is consumed by the datapath directly, not by the decoder.
  logic unused_operand;
  assign unused_operand = ^Instruction[3:0];

  logic       jmp, beq, lut_we, lut_re, lut_hi;
  logic       reg_we, reg_alu, reg_mem, reg_acc;
  logic       acc_we, acc_reg, acc_alu, acc_imm, acc_hi;
  logic       mem_we;
  logic [4:0] alu_op;
  logic       ack_q, ack_d;

  // Opcodes with X/Z bits match no item and fall to the all-zero default.
  always_comb begin
    jmp = 1'b0; beq = 1'b0; lut_we = 1'b0; lut_re = 1'b0; lut_hi = 1'b0;
    reg_we = 1'b0; reg_alu = 1'b0; reg_mem = 1'b0; reg_acc = 1'b0;
    acc_we = 1'b0; acc_reg = 1'b0; acc_alu = 1'b0; acc_imm = 1'b0;
    acc_hi = 1'b0; mem_we = 1'b0; alu_op = 5'h00;
    ack_d  = ack_q;
    case (opcode)
      5'h01: ack_d = 1'b1;
      5'h02: begin acc_we = 1'b1; acc_imm = 1'b1; end
      5'h03: begin acc_we = 1'b1; acc_imm = 1'b1; acc_hi = 1'b1; end
      5'h04: begin acc_we = 1'b1; acc_reg = 1'b1; end
      5'h05: begin reg_we = 1'b1; reg_acc = 1'b1; end
      5'h06: begin reg_we = 1'b1; reg_mem = 1'b1; end
      5'h07: mem_we = 1'b1;
      5'h08: lut_we = 1'b1;
      5'h09: begin lut_we = 1'b1; lut_hi = 1'b1; end
      5'h0A: begin lut_re = 1'b1; jmp = 1'b1; end
      5'h0B: begin lut_re = 1'b1; beq = (AccInput == 8'h00); end
      5'h0C: begin lut_re = 1'b1; beq = (AccInput != 8'h00); end
      5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17: begin
        acc_we = 1'b1; acc_alu = 1'b1; alu_op = {2'b00, opcode[2:0]};
      end
      5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F: begin
        reg_we = 1'b1; reg_alu = 1'b1; alu_op = {2'b00, opcode[2:0]};
      end
      default: ;
    endcase
  end

  // During reset every state-changing enable is suppressed. The data selects
  // are suppressed too, so a select is never high without its write enable.
  assign PC_Jmp_Flag  = jmp     & Reset_n;
  assign PC_Beq_Flag  = beq     & Reset_n;
  assign LUT_Write_En = lut_we  & Reset_n;
  assign LUT_Read_En  = lut_re;
  assign LUT_Load_Hi  = lut_hi;
  assign Reg_Write_En = reg_we  & Reset_n;
  assign Reg_From_ALU = reg_alu & Reset_n;
  assign Reg_From_Mem = reg_mem & Reset_n;
  assign Reg_From_Acc = reg_acc & Reset_n;
  assign Acc_Write_En = acc_we  & Reset_n;
  assign Acc_From_Reg = acc_reg & Reset_n;
  assign Acc_From_ALU = acc_alu & Reset_n;
  assign Acc_From_Imm = acc_imm & Reset_n;
  assign Acc_Load_Hi  = acc_hi;
  assign Mem_Write_En = mem_we  & Reset_n;
  assign ALU_Opcode   = alu_op;

  // Ack: reset has priority over a HALT presented in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) ack_q <= 1'b0;
    else          ack_q <= ack_d;
  end

  assign Ack = ack_q;

endmodule

// File: tb/tb_ctrl_decoder.sv
module tb_ctrl_decoder;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [8:0] Instruction;
  logic [7:0] AccInput;
  logic       PC_Jmp_Flag, PC_Beq_Flag, LUT_Write_En, LUT_Read_En, LUT_Load_Hi;
  logic       Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc;
  logic       Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm, Acc_Load_Hi;
  logic       Mem_Write_En, Ack;
  logic [4:0] ALU_Opcode, op_mnemonic;

  int total = 0;
  int bad   = 0;

  ctrl_decoder dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instruction(Instruction), .AccInput(AccInput),
    .PC_Jmp_Flag(PC_Jmp_Flag), .PC_Beq_Flag(PC_Beq_Flag),
    .LUT_Write_En(LUT_Write_En), .LUT_Read_En(LUT_Read_En), .LUT_Load_Hi(LUT_Load_Hi),
    .Reg_Write_En(Reg_Write_En), .Reg_From_ALU(Reg_From_ALU),
    .Reg_From_Mem(Reg_From_Mem), .Reg_From_Acc(Reg_From_Acc),
    .Acc_Write_En(Acc_Write_En), .Acc_From_Reg(Acc_From_Reg),
    .Acc_From_ALU(Acc_From_ALU), .Acc_From_Imm(Acc_From_Imm),
    .Acc_Load_Hi(Acc_Load_Hi), .Mem_Write_En(Mem_Write_En), .Ack(Ack),
    .ALU_Opcode(ALU_Opcode), .op_mnemonic(op_mnemonic)
  );

  always #5 Clk = ~Clk;

  // Bit order: JMP BEQ LUT_W LUT_R LUT_HI REG_W R_ALU R_MEM R_ACC
  //            ACC_W A_REG A_ALU A_IMM A_HI MEM_W
  logic [14:0] dec_vec;
  assign dec_vec = {PC_Jmp_Flag, PC_Beq_Flag, LUT_Write_En, LUT_Read_En, LUT_Load_Hi,
                    Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc,
                    Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm,
                    Acc_Load_Hi, Mem_Write_En};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-written decode table (AccInput zero-test folded in for 0B/0C).
  function automatic logic [14:0] exp_dec(input logic [4:0] op, input logic acc_zero);
    case (op)
      5'h02: exp_dec = 15'h0024;
      5'h03: exp_dec = 15'h0026;
      5'h04: exp_dec = 15'h0030;
      5'h05: exp_dec = 15'h0240;
      5'h06: exp_dec = 15'h0280;
      5'h07: exp_dec = 15'h0001;
      5'h08: exp_dec = 15'h1000;
      5'h09: exp_dec = 15'h1400;
      5'h0A: exp_dec = 15'h4800;
      5'h0B: exp_dec = acc_zero ? 15'h2800 : 15'h0800;
      5'h0C: exp_dec = acc_zero ? 15'h0800 : 15'h2800;
      default: begin
        if (op >= 5'h18)      exp_dec = 15'h0300;
        else if (op >= 5'h10) exp_dec = 15'h0028;
        else                  exp_dec = 15'h0000;
      end
    endcase
  endfunction

  task automatic apply(input logic [8:0] ins, input logic [7:0] acc);
    @(negedge Clk);
    Instruction = ins;
    AccInput    = acc;
    #1;
  endtask

  initial begin
    Reset_n     = 1'b0;
    Instruction = 9'h000;
    AccInput    = 8'h00;

    // Reset state
    @(posedge Clk); #1;
    chk("reset_ack", Ack, 0);
    chk("reset_dec", dec_vec, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Opcode sweep, operand 0, AccInput 0
    for (int op = 0; op < 32; op++) begin
      apply({op[4:0], 4'h0}, 8'h00);
      chk($sformatf("mn_%02h", op), op_mnemonic, op);
      chk($sformatf("dec_%02h", op), dec_vec, exp_dec(op[4:0], 1'b1));
      chk($sformatf("alu_%02h", op), ALU_Opcode, (op >= 16) ? (op & 7) : 0);
    end

    // Conditional branches
    apply({5'h0B, 4'h3}, 8'h00); chk("beqz_z_beq", PC_Beq_Flag, 1); chk("beqz_z_jmp", PC_Jmp_Flag, 0);
    apply({5'h0B, 4'h3}, 8'h5A); chk("beqz_nz_beq", PC_Beq_Flag, 0); chk("beqz_nz_jmp", PC_Jmp_Flag, 0);
    apply({5'h0C, 4'h3}, 8'h00); chk("bnez_z_beq", PC_Beq_Flag, 0); chk("bnez_z_jmp", PC_Jmp_Flag, 0);
    apply({5'h0C, 4'h3}, 8'h5A); chk("bnez_nz_beq", PC_Beq_Flag, 1); chk("bnez_nz_jmp", PC_Jmp_Flag, 0);
    chk("bnez_nz_vec", dec_vec, exp_dec(5'h0C, 1'b0));

    // ALU ops with non-zero operands
    apply({5'h13, 4'h7}, 8'h11);
    chk("op13_alu", ALU_Opcode, 5'h03);
    chk("op13_vec", dec_vec, 15'h0028);
    apply({5'h1E, 4'hC}, 8'h11);
    chk("op1e_alu", ALU_Opcode, 5'h06);
    chk("op1e_vec", dec_vec, 15'h0300);

    // Ack: clear, HALT, hold, reset
    @(negedge Clk); Reset_n = 1'b0; Instruction = 9'h000;
    @(posedge Clk); #1; chk("ack_cleared", Ack, 0);
    @(negedge Clk); Reset_n = 1'b1; Instruction = {5'h01, 4'h0};
    @(posedge Clk); #1; chk("ack_set", Ack, 1);
    @(negedge Clk); Instruction = 9'h000;
    @(posedge Clk); #1; chk("ack_hold1", Ack, 1);
    @(posedge Clk); #1; chk("ack_hold2", Ack, 1);
    @(negedge Clk); Reset_n = 1'b0;
    @(posedge Clk); #1; chk("ack_reset", Ack, 0);

    // Enables suppressed during reset; HALT ignored under reset
    apply({5'h07, 4'h0}, 8'h00); chk("rst_st_mem", Mem_Write_En, 0);
    apply({5'h0A, 4'h0}, 8'h00); chk("rst_jmp", PC_Jmp_Flag, 0);
    apply({5'h01, 4'h0}, 8'h00);
    @(posedge Clk); #1; chk("rst_halt_ack", Ack, 0);
    apply({5'h13, 4'h0}, 8'h00); chk("rst_alu_accwe", Acc_Write_En, 0);
    @(negedge Clk); Reset_n = 1'b1; Instruction = {5'h07, 4'h0}; #1;
    chk("post_rst_st", Mem_Write_En, 1);

    // Unknown instruction and reserved opcodes
    apply(9'bx, 8'h00);
    chk("x_dec", dec_vec, 0);
    chk("x_alu", ALU_Opcode, 0);
    for (int op = 13; op < 16; op++) begin
      apply({op[4:0], 4'hF}, 8'h00);
      chk($sformatf("resv_%02h", op), dec_vec, 0);
      chk($sformatf("resv_alu_%02h", op), ALU_Opcode, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
